// File: rtl/i2c_pkg.sv
// Shared I2C types: responder state encoding and bus ACK/NACK levels.
`timescale 1ns/1ps
package i2c_pkg;
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WRITE, WR_ACK, READ, RD_ACK, IGNORE
    } i2c_resp_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;
endpackage

// File: rtl/i2c_bus_sync_edge.sv
// SCL/SDA synchronizer with SCL edge and START/STOP pulse detection.
// Detection is held off until the chain holds real bus samples after reset.
`timescale 1ns/1ps
module i2c_bus_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);
    logic [SYNC_STAGES-1:0] scl_ff, sda_ff;
    logic                   scl_q, sda_q;
    logic [2:0]             arm_cnt;
    logic                   armed;
    logic                   scl;

    assign scl   = scl_ff[SYNC_STAGES-1];
    assign sda   = sda_ff[SYNC_STAGES-1];
    assign armed = (arm_cnt == 3'(SYNC_STAGES + 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            scl_ff  <= '1;
            sda_ff  <= '1;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
            arm_cnt <= '0;
        end else begin
            scl_ff <= {scl_ff[SYNC_STAGES-2:0], scl_i};
            sda_ff <= {sda_ff[SYNC_STAGES-2:0], sda_i};
            scl_q  <= scl;
            sda_q  <= sda;
            if (!armed) arm_cnt <= arm_cnt + 3'd1;
        end
    end

    assign scl_rise  = armed &  scl & ~scl_q;
    assign scl_fall  = armed & ~scl &  scl_q;
    assign start_det = armed & scl & scl_q &  sda_q & ~sda;
    assign stop_det  = armed & scl & scl_q & ~sda_q &  sda;
endmodule

// File: rtl/i2c_target_responder.sv
// I2C target: ACKs writes to TARGET_ADDR and serves reads from rd_data_i.
// Define I2C_RESP_CLK_STRETCH_EN to stretch SCL until read data is valid.
`timescale 1ns/1ps
module i2c_target_responder #(
    parameter logic [6:0] TARGET_ADDR = 7'h22,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_drv_o,
    output logic       scl_drv_o,
    output logic [7:0] wr_data_o,
    output logic       wr_valid_o,
    output logic       rd_req_o,
    input  logic [7:0] rd_data_i,
    input  logic       rd_valid_i,
    output logic       busy_o
);
    import i2c_pkg::*;

`ifdef I2C_RESP_CLK_STRETCH_EN
    localparam logic STRETCH = 1'b1;
`else
    localparam logic STRETCH = 1'b0;
`endif

    logic sda, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_resp_state_t state;
    logic [7:0]      sh;
    logic [3:0]      cnt;
    logic            phase;     // ACK slot: 0 = before drive, 1 = driving
    logic            rw;
    logic            pending;   // read byte requested, not yet loaded
    logic            mack;
    logic            scl_hold;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            sh         <= '0;
            cnt        <= '0;
            phase      <= 1'b0;
            rw         <= 1'b0;
            pending    <= 1'b0;
            mack       <= I2C_NACK;
            scl_hold   <= 1'b0;
            sda_drv_o  <= 1'b0;
            wr_data_o  <= '0;
            wr_valid_o <= 1'b0;
            rd_req_o   <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            wr_valid_o <= 1'b0;
            rd_req_o   <= 1'b0;
            if (stop_det) begin
                state     <= IDLE;
                sda_drv_o <= 1'b0;
                scl_hold  <= 1'b0;
                pending   <= 1'b0;
                busy_o    <= 1'b0;
            end else if (start_det) begin
                state     <= ADDR;
                cnt       <= '0;
                sda_drv_o <= 1'b0;
                scl_hold  <= 1'b0;
                pending   <= 1'b0;
            end else begin
                case (state)
                    ADDR: if (scl_rise) begin
                        sh  <= {sh[6:0], sda};
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt   <= '0;
                            phase <= 1'b0;
                            rw    <= sda;
                            if (sh[6:0] == TARGET_ADDR) begin
                                state  <= ADDR_ACK;
                                busy_o <= 1'b1;
                            end else begin
                                state  <= IGNORE;
                                busy_o <= 1'b0;
                            end
                        end
                    end
                    ADDR_ACK, WR_ACK: if (scl_fall) begin
                        if (!phase) begin
                            sda_drv_o <= 1'b1;
                            phase     <= 1'b1;
                        end else begin
                            sda_drv_o <= 1'b0;
                            phase     <= 1'b0;
                            cnt       <= '0;
                            if (state == ADDR_ACK && rw) begin
                                state    <= READ;
                                rd_req_o <= 1'b1;
                                pending  <= 1'b1;
                                scl_hold <= STRETCH;
                            end else begin
                                state <= WRITE;
                            end
                        end
                    end
                    WRITE: if (scl_rise) begin
                        sh  <= {sh[6:0], sda};
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            wr_data_o  <= {sh[6:0], sda};
                            wr_valid_o <= 1'b1;
                            state      <= WR_ACK;
                            cnt        <= '0;
                            phase      <= 1'b0;
                        end
                    end
                    READ: begin
                        if (pending) begin
                            // MSB goes out as soon as data lands; late data in the
                            // non-stretch build leaves SDA released, i.e. 8'hFF.
                            if (rd_valid_i) begin
                                sh        <= rd_data_i;
                                sda_drv_o <= ~rd_data_i[7];
                                pending   <= 1'b0;
                                cnt       <= {3'b0, scl_rise};
                            end else if (scl_rise && !STRETCH) begin
                                sh      <= 8'hFF;
                                pending <= 1'b0;
                                cnt     <= 4'd1;
                            end
                        end else begin
                            if (scl_hold) scl_hold <= 1'b0;
                            if (scl_rise) cnt <= cnt + 4'd1;
                            if (scl_fall) begin
                                if (cnt == 4'd8) begin
                                    sda_drv_o <= 1'b0;
                                    state     <= RD_ACK;
                                    cnt       <= '0;
                                end else begin
                                    sh        <= {sh[6:0], 1'b1};
                                    sda_drv_o <= ~sh[6];
                                end
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) mack <= sda;
                        if (scl_fall) begin
                            if (mack == I2C_ACK) begin
                                state    <= READ;
                                rd_req_o <= 1'b1;
                                pending  <= 1'b1;
                                scl_hold <= STRETCH;
                                cnt      <= '0;
                            end else begin
                                state     <= IGNORE;
                                sda_drv_o <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef I2C_RESP_CLK_STRETCH_EN
    assign scl_drv_o = scl_hold;
`else
    assign scl_drv_o = 1'b0;
`endif
endmodule

// File: tb/tb_i2c_target_responder.sv
// Directed bench: bit-banged I2C master, read-data host, and a transaction-level
// model checked every cycle against the responder outputs.
`timescale 1ns/1ps
module tb_i2c_target_responder;
    localparam int Q = 10;   // clk cycles per quarter SCL period

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       scl_m = 1'b1, sda_m = 1'b1;
    logic       scl_bus, sda_bus, sda_drv, scl_drv, wr_valid, rd_req, busy;
    logic       rd_valid = 1'b0;
    logic [7:0] rd_data = 8'h00, wr_data;

    int nchk = 0, nfail = 0;
    int rd_delay = 1;
    int rd_req_cnt = 0, stretch_cyc = 0;
    bit silent = 1'b0;
    logic [7:0] exp_wr[$];
    logic [7:0] rd_q[$];

    always #5 clk = ~clk;

    assign scl_bus = scl_m & ~scl_drv;
    assign sda_bus = sda_m & ~sda_drv;

    i2c_target_responder #(.TARGET_ADDR(7'h22), .SYNC_STAGES(2)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .scl_i      (scl_bus),
        .sda_i      (sda_bus),
        .sda_drv_o  (sda_drv),
        .scl_drv_o  (scl_drv),
        .wr_data_o  (wr_data),
        .wr_valid_o (wr_valid),
        .rd_req_o   (rd_req),
        .rd_data_i  (rd_data),
        .rd_valid_i (rd_valid),
        .busy_o     (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Bus-level ACK bit the model predicts for an address byte.
    function automatic logic model_ack(input logic [7:0] a);
        return (a[7:1] == 7'h22) ? 1'b0 : 1'b1;
    endfunction

    // Per-cycle compare against the model.
    logic prev_wr = 1'b0, prev_rd = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset sda_drv", sda_drv, 0);
            chk("reset scl_drv", scl_drv, 0);
            chk("reset wr_valid", wr_valid, 0);
            chk("reset rd_req", rd_req, 0);
            chk("reset busy", busy, 0);
            chk("reset wr_data", wr_data, 8'h00);
        end else begin
            if (wr_valid) begin
                chk("wr_valid expected", exp_wr.size() != 0, 1);
                if (exp_wr.size() != 0) chk("wr_data", wr_data, exp_wr.pop_front());
                chk("wr_valid one cycle", prev_wr, 0);
            end
            if (rd_req) begin
                rd_req_cnt++;
                chk("rd_req one cycle", prev_rd, 0);
            end
            if (silent) chk("sda released", sda_drv, 0);
`ifndef I2C_RESP_CLK_STRETCH_EN
            chk("scl_drv tied", scl_drv, 0);
`endif
            if (scl_drv) stretch_cyc++;
        end
        prev_wr = wr_valid;
        prev_rd = rd_req;
    end

    // Read-data host: answers each request after rd_delay cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (rd_req) begin
                repeat (rd_delay) @(posedge clk);
                #1;
                rd_data  = (rd_q.size() != 0) ? rd_q.pop_front() : 8'h00;
                rd_valid = 1'b1;
                @(posedge clk);
                #1 rd_valid = 1'b0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clk_bit(input logic b, output logic r);
        int t;
        sda_m = b;
        cyc(Q);
        scl_m = 1'b1;
        t = 0;
        while (scl_bus !== 1'b1 && t < 2000) begin
            cyc(1);
            t++;
        end
        if (t >= 2000) chk("scl release timeout", scl_bus, 1);
        cyc(Q);
        r = sda_bus;
        cyc(Q);
        scl_m = 1'b0;
        cyc(Q);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; cyc(Q);
        scl_m = 1'b1; cyc(Q);
        sda_m = 1'b0; cyc(Q);
        scl_m = 1'b0; cyc(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; cyc(Q);
        scl_m = 1'b1; cyc(Q);
        sda_m = 1'b1; cyc(Q);
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], r);
        clk_bit(1'b1, ack);
    endtask

    task automatic rd_byte(input logic mack, output logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, r);
            b[i] = r;
        end
        clk_bit(mack, r);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack, r;
        logic [7:0] b;
        int         base;

        cyc(5);
        rst_n = 1'b1;
        cyc(5);
        chk("post-reset busy", busy, 0);

        // Write 0xA5, 0x3C to 0x22
        i2c_start();
        wr_byte(8'h44, ack);
        chk("write addr ack", ack, model_ack(8'h44));
        chk("busy after match", busy, 1);
        exp_wr.push_back(8'hA5);
        wr_byte(8'hA5, ack);
        chk("data A5 ack", ack, 0);
        exp_wr.push_back(8'h3C);
        wr_byte(8'h3C, ack);
        chk("data 3C ack", ack, 0);
        chk("wr bytes delivered", exp_wr.size(), 0);
        i2c_stop();
        chk("busy after stop", busy, 0);

        // Wrong address 0x23: no response at all
        silent = 1'b1;
        i2c_start();
        wr_byte(8'h46, ack);
        chk("wrong addr nack", ack, model_ack(8'h46));
        chk("busy on mismatch", busy, 0);
        wr_byte(8'h55, ack);
        chk("ignored data nack", ack, 1);
        i2c_stop();
        silent = 1'b0;

        // Read 0x5A (ACK) then 0xC3 (NACK)
        base = rd_req_cnt;
        rd_q.push_back(8'h5A);
        rd_q.push_back(8'hC3);
        i2c_start();
        wr_byte(8'h45, ack);
        chk("read addr ack", ack, model_ack(8'h45));
        rd_byte(1'b0, b);
        chk("read byte 0", b, 8'h5A);
        rd_byte(1'b1, b);
        chk("read byte 1", b, 8'hC3);
        cyc(2);
        chk("sda after nack", sda_drv, 0);
        i2c_stop();
        chk("rd_req pulses", rd_req_cnt - base, 2);

        // Write then repeated START into a read
        base = rd_req_cnt;
        i2c_start();
        wr_byte(8'h44, ack);
        chk("rs write addr ack", ack, 0);
        exp_wr.push_back(8'hA5);
        wr_byte(8'hA5, ack);
        chk("rs data ack", ack, 0);
        rd_q.push_back(8'h96);
        i2c_start();
        wr_byte(8'h45, ack);
        chk("rs read addr ack", ack, 0);
        rd_byte(1'b1, b);
        chk("rs read byte", b, 8'h96);
        i2c_stop();
        chk("rs wr delivered", exp_wr.size(), 0);
        chk("rs rd_req pulses", rd_req_cnt - base, 1);

        // Reset mid-read while driving a 0 bit
        rd_q.push_back(8'h00);
        i2c_start();
        wr_byte(8'h45, ack);
        chk("pre-reset addr ack", ack, 0);
        for (int i = 0; i < 3; i++) clk_bit(1'b1, r);
        chk("driving bit 4", sda_drv, 1);
        rst_n = 1'b0;
        #1;
        chk("async release", sda_drv, 0);
        cyc(3);
        rst_n = 1'b1;
        silent = 1'b1;
        for (int i = 0; i < 5; i++) clk_bit(1'b1, r);
        wr_byte(8'h44, ack);
        chk("no ack without start", ack, 1);
        chk("busy after reset", busy, 0);
        silent = 1'b0;
        i2c_start();
        wr_byte(8'h44, ack);
        chk("ack after fresh start", ack, 0);
        i2c_stop();

        // Late read data: stretched or 0xFF
        rd_delay = 50;
        stretch_cyc = 0;
        rd_q.push_back(8'h5A);
        i2c_start();
        wr_byte(8'h45, ack);
        chk("late addr ack", ack, 0);
        rd_byte(1'b1, b);
`ifdef I2C_RESP_CLK_STRETCH_EN
        chk("stretched byte", b, 8'h5A);
        chk("stretch length", (stretch_cyc >= 45 && stretch_cyc <= 60), 1);
`else
        chk("late byte is FF", b, 8'hFF);
        chk("no stretch", stretch_cyc, 0);
`endif
        i2c_stop();
        rd_delay = 1;
        cyc(60);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
